// File: rtl/cb_zigzag_serializer_if.sv
// ---------------------------------------------------------------------------
// cb_zigzag_serializer_if
//   Bundles the block input strobe and parallel block, plus the zigzag
//   serial output stream with its handshake and status flags.
//
//   in_enable  1-cycle strobe: Q_in holds a valid 8x8 block
//   Q_in       signed 8x8 quantized Cb block, [row][col]
//   out_valid  out_coeff/out_index valid this cycle
//   out_ready  downstream accepts when out_valid && out_ready
//   out_coeff  signed coefficient in zigzag order
//   out_index  zigzag position 0..63 of out_coeff
//   out_sob    start of block (index 0 presented)
//   out_eob    end of block (index 63 presented)
//   overflow   sticky: a block was dropped because both banks were full
//
//   master : the environment (quantizer upstream, RLE/Huffman downstream)
//   slave  : the serializer itself
// ---------------------------------------------------------------------------
interface cb_zigzag_serializer_if #(
  parameter int DATA_W = 11
);
  logic                     in_enable;
  logic signed [DATA_W-1:0] Q_in [8][8];
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_coeff;
  logic [5:0]               out_index;
  logic                     out_sob;
  logic                     out_eob;
  logic                     overflow;

  modport master (
    output in_enable, Q_in, out_ready,
    input  out_valid, out_coeff, out_index, out_sob, out_eob, overflow
  );

  modport slave (
    input  in_enable, Q_in, out_ready,
    output out_valid, out_coeff, out_index, out_sob, out_eob, overflow
  );
endinterface

// File: rtl/cb_zigzag_serializer.sv
// ---------------------------------------------------------------------------
// cb_zigzag_serializer
//   Captures a parallel 8x8 quantized Cb block and streams it out one
//   coefficient per cycle in JPEG zigzag order. Two banks (ping-pong) let a
//   new block be captured while the previous one is still draining.
//
//   clk   clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   cb_zigzag_serializer_if.slave (block input, serial output stream,
//         overflow status)
// ---------------------------------------------------------------------------
module cb_zigzag_serializer #(
  parameter int DATA_W = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  cb_zigzag_serializer_if.slave     bus
);

  // Zigzag position -> raster index (row*8+col).
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [1:0] fill_cnt_reg;
  logic       wr_bank_reg;
  logic       rd_bank_reg;
  logic [5:0] rd_idx_reg;
  logic       overflow_reg;

  logic signed [DATA_W-1:0] q_flat   [64];
  logic signed [DATA_W-1:0] bank_mem [2][64];

  logic out_valid_int;
  logic handshake;
  logic last_beat;
  logic bank_free;
  logic capture;
  logic drop;

  // Flatten the [row][col] block into raster order.
  for (genvar gi = 0; gi < 64; gi++) begin : g_flat
    assign q_flat[gi] = bus.Q_in[gi / 8][gi % 8];
  end

  assign out_valid_int = (fill_cnt_reg != 2'd0);
  assign handshake     = out_valid_int && bus.out_ready;
  assign last_beat     = handshake && (rd_idx_reg == 6'd63);

  // With both banks full, the bank finishing its final beat on this edge is
  // already free for the incoming block; its last word is read out before
  // the overwrite lands.
  assign bank_free = (fill_cnt_reg < 2'd2) || last_beat;
  assign capture   = bus.in_enable && bank_free;
  assign drop      = bus.in_enable && !bank_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt_reg <= 2'd0;
      wr_bank_reg  <= 1'b0;
      rd_bank_reg  <= 1'b0;
      rd_idx_reg   <= 6'd0;
      overflow_reg <= 1'b0;
    end else begin
      unique case ({capture, last_beat})
        2'b10:   fill_cnt_reg <= fill_cnt_reg + 2'd1;
        2'b01:   fill_cnt_reg <= fill_cnt_reg - 2'd1;
        default: fill_cnt_reg <= fill_cnt_reg;
      endcase
      if (capture) begin
        wr_bank_reg <= ~wr_bank_reg;
      end
      if (handshake) begin
        rd_idx_reg <= rd_idx_reg + 6'd1;  // 63 wraps to 0
      end
      if (last_beat) begin
        rd_bank_reg <= ~rd_bank_reg;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Bank storage is not reset; it is only ever read while marked full.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < 64; i++) begin
        bank_mem[wr_bank_reg][i] <= q_flat[i];
      end
    end
  end

  assign bus.out_valid = out_valid_int;
  assign bus.out_index = rd_idx_reg;
  assign bus.out_coeff = out_valid_int ? bank_mem[rd_bank_reg][ZZ[rd_idx_reg]] : '0;
  assign bus.out_sob   = out_valid_int && (rd_idx_reg == 6'd0);
  assign bus.out_eob   = out_valid_int && (rd_idx_reg == 6'd63);
  assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_cb_zigzag_serializer.sv
// ---------------------------------------------------------------------------
// tb_cb_zigzag_serializer
//   Scoreboard bench: the driver issues blocks and handshakes; a negedge
//   monitor predicts captures/drops from its own queue of expected beats
//   (built by walking the 8x8 anti-diagonals) and compares every cycle.
// ---------------------------------------------------------------------------
module tb_cb_zigzag_serializer;
  localparam int DATA_W = 11;

  typedef struct {
    logic signed [DATA_W-1:0] coeff;
    int                       idx;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cb_zigzag_serializer_if #(.DATA_W(DATA_W)) bus ();

  cb_zigzag_serializer #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    tests  = 0;
  int    fails  = 0;
  int    zz_ref [64];
  beat_t exp_q  [$];
  logic  model_ovf = 1'b0;

  function automatic void check(input string name, input logic signed [31:0] act,
                                input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference zigzag: walk anti-diagonals s=row+col, alternating direction.
  function automatic void build_zigzag();
    int k;
    int lo;
    int hi;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 8) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin
          zz_ref[k] = r * 8 + (s - r);
          k++;
        end
      end else begin
        for (int r = lo; r <= hi; r++) begin
          zz_ref[k] = r * 8 + (s - r);
          k++;
        end
      end
    end
  endfunction

  // Monitor / scoreboard: models what happens at the coming rising edge.
  always @(negedge clk) begin
    int    blocks;
    bit    hs;
    bit    last;
    beat_t b;
    int    raster;
    if (rst) begin
      exp_q.delete();
      model_ovf = 1'b0;
      check("reset_valid", 32'(bus.out_valid), 0);
      check("reset_overflow", 32'(bus.overflow), 0);
      check("reset_index", 32'(bus.out_index), 0);
    end else begin
      check("valid", 32'(bus.out_valid), (exp_q.size() != 0) ? 1 : 0);
      check("overflow", 32'(bus.overflow), 32'(model_ovf));
      if (exp_q.size() != 0 && bus.out_valid) begin
        check("coeff", 32'(bus.out_coeff), 32'(exp_q[0].coeff));
        check("index", 32'(bus.out_index), exp_q[0].idx);
        check("sob", 32'(bus.out_sob), (exp_q[0].idx == 0) ? 1 : 0);
        check("eob", 32'(bus.out_eob), (exp_q[0].idx == 63) ? 1 : 0);
      end
      blocks = (exp_q.size() + 63) / 64;
      hs     = (exp_q.size() != 0) && bus.out_ready;
      last   = hs && (exp_q[0].idx == 63);
      if (hs) void'(exp_q.pop_front());
      if (bus.in_enable) begin
        if (blocks < 2 || last) begin
          for (int k = 0; k < 64; k++) begin
            raster  = zz_ref[k];
            b.coeff = bus.Q_in[raster / 8][raster % 8];
            b.idx   = k;
            exp_q.push_back(b);
          end
          $display("[TB] block captured, first raster value %0d", bus.Q_in[0][0]);
        end else begin
          model_ovf = 1'b1;
          $display("[TB] block dropped (both banks full)");
        end
      end
    end
  end

  // kind: 0 raster ramp, 1 constant val, 2 random, 3 signed extremes
  task automatic send_block(input int kind, input int val);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        case (kind)
          0:       bus.Q_in[r][c] = DATA_W'(r * 8 + c);
          1:       bus.Q_in[r][c] = DATA_W'(val);
          2:       bus.Q_in[r][c] = DATA_W'($urandom_range(0, 2047));
          default: bus.Q_in[r][c] = ($urandom_range(0, 1) == 0) ? -11'sd1024 : 11'sd1023;
        endcase
      end
    end
    bus.in_enable = 1'b1;
    @(posedge clk);
    #1;
    bus.in_enable = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input bit toggle_ready);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      if (toggle_ready) bus.out_ready = ~bus.out_ready;
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    build_zigzag();
    bus.in_enable = 1'b0;
    bus.out_ready = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        bus.Q_in[r][c] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: single raster block, ready held high
    bus.out_ready = 1'b1;
    send_block(0, 0);
    wait_drain(200, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // 2: back-to-back +5 / -7 blocks, 64 cycles apart
    send_block(1, 5);
    repeat (63) @(posedge clk);
    #1;
    send_block(1, -7);
    wait_drain(300, 1'b0);
    check("t2_overflow", 32'(bus.overflow), 0);

    // 3: alternating backpressure
    bus.out_ready = 1'b1;
    send_block(2, 0);
    wait_drain(300, 1'b1);
    bus.out_ready = 1'b1;

    // 5: buffer full, new block on the edge of the final handshake
    send_block(2, 0);
    send_block(2, 0);
    n = 0;
    while (exp_q.size() != 65 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t5_reach_last", exp_q.size(), 65);
    send_block(0, 0);
    wait_drain(300, 1'b0);
    check("t5_overflow", 32'(bus.overflow), 0);

    // 4: overflow with three strobes under full stall
    bus.out_ready = 1'b0;
    send_block(1, 1);
    send_block(1, 2);
    send_block(1, 3);
    @(posedge clk);
    #1;
    check("t4_overflow", 32'(bus.overflow), 1);
    bus.out_ready = 1'b1;
    wait_drain(400, 1'b0);

    // 6: asynchronous reset at beat 30
    send_block(2, 0);
    n = 0;
    while (!(exp_q.size() != 0 && exp_q[0].idx == 30) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t6_reach_beat30", exp_q[0].idx, 30);
    #1;
    rst = 1'b1;
    #1;
    check("t6_async_valid", 32'(bus.out_valid), 0);
    check("t6_async_overflow", 32'(bus.overflow), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_block(0, 0);
    wait_drain(200, 1'b0);

    // signed extremes, then randomized traffic
    send_block(3, 0);
    wait_drain(200, 1'b0);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 50) == 0) begin
        send_block(2, 0);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    bus.out_ready = 1'b1;
    wait_drain(400, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
